// File: rtl/mem_buffer_if.sv
// mem_buffer_if: push/pop bus between a byte driver and mem_buffer.
//   master : driver side; drives write_en/data_in/read_en and observes the rest.
//   slave  : buffer side; drives data_out/data_valid/full/empty/count/overflow/underflow.
interface mem_buffer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
);
    logic                     write_en;
    logic [DATA_W-1:0]        data_in;
    logic                     read_en;
    logic [DATA_W-1:0]        data_out;
    logic                     data_valid;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output write_en, data_in, read_en,
        input  data_out, data_valid, full, empty, count, overflow, underflow
    );

    modport slave (
        input  write_en, data_in, read_en,
        output data_out, data_valid, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/mem_buffer.sv
// mem_buffer: DEPTH x DATA_W first-in first-out byte buffer with registered pop data,
// occupancy flags and one-cycle overflow/underflow pulses.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mem_buffer_if.slave (write_en/data_in push, read_en pop, data_out/data_valid
//            registered pop result, full/empty/count occupancy, overflow/underflow pulses)
// DEPTH must be a power of two and at least 2 so the pointers wrap by plain overflow.
module mem_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input logic        clk,
    input logic        rst_n,
    mem_buffer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] data_out_q;
    logic              data_valid_q;
    logic              overflow_q;
    logic              underflow_q;

    logic full, empty;
    logic rd_acc, wr_acc;

    // Flags decode from the registered count only.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A write into a full buffer still lands when a read frees a slot on the same edge.
    // A read on an empty buffer never falls through to a concurrent write.
    always_comb begin
        rd_acc  = bus.read_en && !empty;
        wr_acc  = bus.write_en && (!full || rd_acc);
        count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            data_valid_q <= rd_acc;
            overflow_q   <= bus.write_en && full && !rd_acc;
            underflow_q  <= bus.read_en && empty;
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                data_out_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage is not reset; stale entries are unreachable because the pointers are.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
endmodule
